// File: rtl/uart_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_bus_pkg
// Brief   : Shared types and constants for the UART core register bus:
//           bus widths, bus-master FSM state encoding, register map.
// Revision: 1.0 - initial release
// ============================================================================
package uart_bus_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  // Bus-master transaction phases
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    RESP   = 3'd4,
    GAP    = 3'd5
  } state_t;

  // UART core register map (16550-style layout)
  localparam logic [ADDR_W-1:0] REG_RBR_THR = 4'h0;
  localparam logic [ADDR_W-1:0] REG_IER     = 4'h1;
  localparam logic [ADDR_W-1:0] REG_IIR_FCR = 4'h2;
  localparam logic [ADDR_W-1:0] REG_LCR     = 4'h3;
  localparam logic [ADDR_W-1:0] REG_MCR     = 4'h4;
  localparam logic [ADDR_W-1:0] REG_LSR     = 4'h5;
  localparam logic [ADDR_W-1:0] REG_MSR     = 4'h6;
  localparam logic [ADDR_W-1:0] REG_SCR     = 4'h7;

endpackage
`default_nettype wire

// File: rtl/uart_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : uart_bus_master
// Brief   : Converts single-beat host commands into timed, active-low strobe
//           register cycles on the UART core bus; returns read data over a
//           valid/ready response and latches rising edges of the core IRQ.
// Revision: 1.0 - initial release
// ============================================================================
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned GAP_CYC    = 1
) (
  input  logic              clk,
  input  logic              rst,
  // host command channel
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  // host response channel (reads only)
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              busy_o,
  // UART core register bus
  output logic [ADDR_W-1:0] AddrBus_o,
  output logic              n_ChipSelect_o,
  output logic              n_rd_o,
  output logic              n_we_o,
  output logic [DATA_W-1:0] DataBus_o,
  input  logic [DATA_W-1:0] DataBus_i,
  // interrupt edge latch
  input  logic              p_IrqSig_i,
  output logic              irq_pending_o,
  input  logic              irq_clr_i
);

  // Reject timing parameters the 4-bit phase counter cannot express
  if (STROBE_CYC == 0 || GAP_CYC == 0 || SETUP_CYC > 15 ||
      STROBE_CYC > 15 || HOLD_CYC > 15 || GAP_CYC > 15) begin : g_param_check
    $error("uart_bus_master: illegal timing parameter (STROBE/GAP must be 1..15, SETUP/HOLD 0..15)");
  end

  // Counter reload values: a phase of N cycles counts N-1 down to 0
  localparam logic [3:0] SETUP_LD  = 4'((SETUP_CYC  == 0) ? 0 : SETUP_CYC  - 1);
  localparam logic [3:0] STROBE_LD = 4'((STROBE_CYC == 0) ? 0 : STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'((HOLD_CYC   == 0) ? 0 : HOLD_CYC   - 1);
  localparam logic [3:0] GAP_LD    = 4'((GAP_CYC    == 0) ? 0 : GAP_CYC    - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Bus outputs are computed from the next state and registered
  logic              bus_active_d;
  logic              cs_n_q, cs_n_d;
  logic              rd_n_q, rd_n_d;
  logic              we_n_q, we_n_d;
  logic [ADDR_W-1:0] addr_bus_q, addr_bus_d;
  logic [DATA_W-1:0] data_bus_q, data_bus_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic              irq_sync_q, irq_prev_q, irq_pending_q;

  // Next-state, phase counter, command latch and next bus values
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          wr_d    = cmd_write_i;
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          if (SETUP_CYC != 0) begin
            state_d = SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            state_d = STROBE;
            cnt_d   = STROBE_LD;
          end
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
        end
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          // Edge closing the last strobe cycle samples the core's read data
          if (!wr_q) begin
            rdata_d = DataBus_i;
          end
          if (HOLD_CYC != 0) begin
            state_d = HOLD;
            cnt_d   = HOLD_LD;
          end else if (wr_q) begin
            state_d = GAP;
            cnt_d   = GAP_LD;
          end else begin
            state_d = RESP;
          end
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          if (wr_q) begin
            state_d = GAP;
            cnt_d   = GAP_LD;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end
      end
      GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    bus_active_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    cs_n_d       = !bus_active_d;
    rd_n_d       = !((state_d == STROBE) && !wr_d);
    we_n_d       = !((state_d == STROBE) && wr_d);
    addr_bus_d   = bus_active_d ? addr_d : '0;
    data_bus_d   = (bus_active_d && wr_d) ? wdata_d : '0;
    rsp_valid_d  = (state_d == RESP);
  end

  // FSM state, command latch and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      addr_bus_q  <= '0;
      data_bus_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      we_n_q      <= we_n_d;
      addr_bus_q  <= addr_bus_d;
      data_bus_q  <= data_bus_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // IRQ rising-edge latch; a coincident set beats the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_sync_q    <= 1'b0;
      irq_prev_q    <= 1'b0;
      irq_pending_q <= 1'b0;
    end else begin
      irq_sync_q    <= p_IrqSig_i;
      irq_prev_q    <= irq_sync_q;
      irq_pending_q <= (irq_sync_q && !irq_prev_q) || (irq_pending_q && !irq_clr_i);
    end
  end

  assign cmd_ready_o    = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rdata_q;
  assign AddrBus_o      = addr_bus_q;
  assign n_ChipSelect_o = cs_n_q;
  assign n_rd_o         = rd_n_q;
  assign n_we_o         = we_n_q;
  assign DataBus_o      = data_bus_q;
  assign irq_pending_o  = irq_pending_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_bus_master
// Brief   : Directed bench for uart_bus_master; read responses are checked
//           by a scoreboard monitor, bus timing by per-cycle expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // default-parameter instance
  logic       cmd_valid, cmd_write, cmd_ready, rsp_valid, rsp_ready, busy;
  logic [3:0] cmd_addr, addr_bus;
  logic [7:0] cmd_wdata, rsp_rdata, data_out, data_in, core_rd_value;
  logic       cs_n, rd_n, we_n, irq_sig, irq_clr, irq_pending;

  // short-timing instance: SETUP=0, STROBE=1, HOLD=0, GAP=3
  logic       cmd1_valid, cmd1_write, cmd1_ready, rsp1_valid, busy1;
  logic [3:0] cmd1_addr, addr_bus1;
  logic [7:0] cmd1_wdata, rsp1_rdata, data_out1;
  logic       cs1_n, rd1_n, we1_n, irq1_pending;

  // core model drives read data only while the read strobe is low
  assign data_in = !rd_n ? core_rd_value : 8'hEE;

  uart_bus_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .busy_o(busy),
    .AddrBus_o(addr_bus), .n_ChipSelect_o(cs_n), .n_rd_o(rd_n), .n_we_o(we_n),
    .DataBus_o(data_out), .DataBus_i(data_in),
    .p_IrqSig_i(irq_sig), .irq_pending_o(irq_pending), .irq_clr_i(irq_clr)
  );

  uart_bus_master #(.SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(0), .GAP_CYC(3)) dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd1_valid), .cmd_ready_o(cmd1_ready), .cmd_write_i(cmd1_write),
    .cmd_addr_i(cmd1_addr), .cmd_wdata_i(cmd1_wdata),
    .rsp_valid_o(rsp1_valid), .rsp_ready_i(1'b1), .rsp_rdata_o(rsp1_rdata),
    .busy_o(busy1),
    .AddrBus_o(addr_bus1), .n_ChipSelect_o(cs1_n), .n_rd_o(rd1_n), .n_we_o(we1_n),
    .DataBus_o(data_out1), .DataBus_i(8'h00),
    .p_IrqSig_i(1'b0), .irq_pending_o(irq1_pending), .irq_clr_i(1'b0)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] rsp_q[$];

  // expected {cs_n, rd_n, we_n, cmd_ready, rsp_valid} per cycle after handshake
  localparam logic [4:0] EXP_W [1:6] = '{5'b01100, 5'b01000, 5'b01000, 5'b01100, 5'b11100, 5'b11110};
  localparam logic [4:0] EXP_R [1:7] = '{5'b01100, 5'b00100, 5'b00100, 5'b01100, 5'b11101, 5'b11100, 5'b11110};
  // short-timing instance, {cs_n, rd_n, we_n, cmd_ready}
  localparam logic [3:0] EXP_1 [1:7] = '{4'b0100, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b0100, 4'b1110};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [4:0] ctl0();
    return {cs_n, rd_n, we_n, cmd_ready, rsp_valid};
  endfunction

  task automatic wait_ready0();
    int n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      n_total++;
      $display("FAIL wait_ready: cmd_ready=%0b after %0d cycles, expected 1", cmd_ready, n);
    end
  endtask

  // Scoreboard monitor: every accepted response must match the queue head
  always @(negedge clk) begin
    #1;
    if (!rst && rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) begin
        n_total++;
        $display("FAIL rsp_unexpected: response 0x%0h emitted, expected none", rsp_rdata);
      end else begin
        check("rsp_rdata", {24'h0, rsp_rdata}, {24'h0, rsp_q.pop_front()});
      end
    end
  end

  // Watchdog bounds the whole run
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d/%0d passed so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_a, cnt_b;
    rst = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 1;
    irq_sig = 0; irq_clr = 0; core_rd_value = 8'h00;
    cmd1_valid = 0; cmd1_write = 0; cmd1_addr = 0; cmd1_wdata = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // ---------------- reset values ----------------
    check("rst_ctl", {27'h0, ctl0()}, 32'b11110);
    check("rst_bus", {20'h0, addr_bus, data_out}, 32'h0);
    check("rst_misc", {21'h0, rsp_rdata, irq_pending, busy}, 32'h0);
    check("rst_ready1", {31'h0, cmd1_ready}, 32'h1);

    // ---------------- short timing, back-to-back writes ----------------
    cmd1_valid = 1; cmd1_write = 1; cmd1_addr = 4'h1; cmd1_wdata = 8'h11;
    cnt_a = 0; cnt_b = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("b2b_ctl_c%0d", k), {28'h0, cs1_n, rd1_n, we1_n, cmd1_ready}, {28'h0, EXP_1[k]});
      if (k == 1) check("b2b_bus_c1", {20'h0, addr_bus1, data_out1}, 32'h111);
      if (k == 6) check("b2b_bus_c6", {20'h0, addr_bus1, data_out1}, 32'h322);
      if (k >= 2 && k <= 5 && cs1_n) cnt_a++;
      if (!we1_n) cnt_b++;
      if (k == 1) begin cmd1_addr = 4'h3; cmd1_wdata = 8'h22; end
      if (k == 6) cmd1_valid = 0;
    end
    // GAP_CYC=3 cycles plus the IDLE accept cycle separate the two chip selects
    check("b2b_cs_high_run", cnt_a, 4);
    check("b2b_we_pulses", cnt_b, 2);

    // ---------------- write 0x2 <= 0xA5 ----------------
    wait_ready0();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h2; cmd_wdata = 8'hA5;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) cmd_valid = 0;
      check($sformatf("wr_ctl_c%0d", k), {27'h0, ctl0()}, {27'h0, EXP_W[k]});
      if (k <= 5) check($sformatf("wr_bus_c%0d", k), {20'h0, addr_bus, data_out},
                        (k <= 4) ? 32'h2A5 : 32'h0);
      if (k == 1) check("wr_busy_c1", {31'h0, busy}, 32'h1);
    end

    // ---------------- read 0x0 -> 0x3C ----------------
    wait_ready0();
    core_rd_value = 8'h3C;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 4'h0; cmd_wdata = 8'hFF;
    rsp_q.push_back(8'h3C);
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) cmd_valid = 0;
      check($sformatf("rd_ctl_c%0d", k), {27'h0, ctl0()}, {27'h0, EXP_R[k]});
      if (k == 2) check("rd_databus_c2", {24'h0, data_out}, 32'h0);
    end

    // ---------------- read 0x5 with stalled response ----------------
    wait_ready0();
    core_rd_value = 8'h5A;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 4'h5;
    rsp_ready = 0;
    rsp_q.push_back(8'h5A);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) cmd_valid = 0;
    end
    core_rd_value = 8'h00;
    for (int j = 0; j < 10; j++) begin
      tick();
      check($sformatf("stall_ctl_%0d", j), {23'h0, cs_n, cmd_ready, rsp_valid, rsp_rdata},
            {23'h0, 3'b101, 8'h5A});
      check($sformatf("stall_addr_%0d", j), {28'h0, addr_bus}, 32'h0);
    end
    rsp_ready = 1;
    tick();
    check("stall_released", {31'h0, rsp_valid}, 32'h0);

    // ---------------- IRQ edge latch ----------------
    wait_ready0();
    irq_sig = 1;
    tick();
    check("irq_c1", {31'h0, irq_pending}, 32'h0);
    tick();
    check("irq_c2_set", {31'h0, irq_pending}, 32'h1);
    irq_clr = 1;
    tick();
    irq_clr = 0;
    check("irq_cleared", {31'h0, irq_pending}, 32'h0);
    cnt_a = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (irq_pending) cnt_a++;
    end
    check("irq_level_no_reset", cnt_a, 0);
    irq_sig = 0;
    repeat (3) tick();
    irq_sig = 1;
    tick();
    irq_clr = 1;  // coincides with the registered rise
    tick();
    irq_clr = 0;
    check("irq_set_beats_clr", {31'h0, irq_pending}, 32'h1);
    irq_sig = 0;
    irq_clr = 1;
    tick();
    irq_clr = 0;
    check("irq_clr2", {31'h0, irq_pending}, 32'h0);

    // ---------------- reset during read strobe ----------------
    irq_sig = 1;
    tick();
    irq_sig = 0;
    tick();
    check("irq_pre_rst", {31'h0, irq_pending}, 32'h1);
    wait_ready0();
    core_rd_value = 8'h77;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 4'h3;
    tick();
    cmd_valid = 0;
    tick();
    check("rst_mid_strobe_low", {31'h0, rd_n}, 32'h0);
    rst = 1;
    tick();
    rst = 0;
    check("rst_mid_ctl", {27'h0, ctl0()}, 32'b11110);
    check("rst_mid_irq_busy", {30'h0, irq_pending, busy}, 32'h0);
    cnt_a = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (rsp_valid || !cs_n) cnt_a++;
    end
    check("rst_no_response", cnt_a, 0);
    check("scoreboard_drained", rsp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
